// File: rtl/wb_stage_pkg.sv
// -----------------------------------------------------------------------------
// wb_stage_pkg
// Shared definitions for the write-back stage:
//   - bus widths (MEM_TO_WB_WD, HILO_WD, WB_TO_RF_WD) and the stall vector width
//   - Stop / NoStop encodings of a stall bit
//   - packed structs giving the field layout of one mem_to_wb slot, of one
//     trace entry and of the wb_to_rf_bus
// Slot field offsets (LSB first): wdata[31:0], waddr[36:32], we[37],
// pc[69:38], lo[101:70], hi[133:102], lo_we[134], hi_we[135].
// -----------------------------------------------------------------------------
package wb_stage_pkg;

  localparam int MEM_TO_WB_WD = 136;
  localparam int HILO_WD      = 66;
  localparam int RF_PORT_WD   = 38;
  localparam int WB_TO_RF_WD  = HILO_WD + 2 * RF_PORT_WD;
  localparam int STALLBUS_WD  = 6;
  localparam int WB_STALL_BIT = 5;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = ~Stop;

  typedef struct packed {
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_t;

  // One mem_to_wb slot; the low bits form exactly a trace entry.
  typedef struct packed {
    hilo_t       hilo;
    logic [31:0] pc;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } slot_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } trace_t;

  typedef struct packed {
    hilo_t       hilo;
    logic        we1;
    logic [4:0]  waddr1;
    logic [31:0] wdata1;
    logic        we0;
    logic [4:0]  waddr0;
    logic [31:0] wdata0;
  } rf_bus_t;

  // Both slots write the same register: the older write must be suppressed.
  function automatic logic same_dest_conflict(input logic we_o, input logic [4:0] wa_o,
                                              input logic we_y, input logic [4:0] wa_y);
    return we_o & we_y & (wa_o == wa_y);
  endfunction

endpackage

// File: rtl/wb_stage_trace_fifo.sv
// -----------------------------------------------------------------------------
// wb_stage_trace_fifo
// Small circular FIFO that serialises up to two retirements per cycle onto a
// single trace port.
//   i_push0/i_data0 : older entry, i_push1/i_data1 : younger entry; pushed
//                     entries are packed in order (older first)
//   o_rd_valid      : an entry is popped on this edge (count != 0)
//   o_rd_data       : the entry at the read pointer
//   o_count         : current occupancy
//   o_full          : occupancy has reached TRACE_DEPTH-1, a dual push could
//                     no longer be guaranteed to fit
// -----------------------------------------------------------------------------
module wb_stage_trace_fifo
  import wb_stage_pkg::*;
#(
  parameter int TRACE_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_push0,
  input  trace_t                       i_data0,
  input  logic                         i_push1,
  input  trace_t                       i_data1,
  output logic                         o_rd_valid,
  output trace_t                       o_rd_data,
  output logic [$clog2(TRACE_DEPTH):0] o_count,
  output logic                         o_full
);

  localparam int PTR_WD = $clog2(TRACE_DEPTH);
  localparam int CNT_WD = PTR_WD + 1;

  trace_t            r_mem [TRACE_DEPTH];
  logic [PTR_WD-1:0] r_wr_ptr;
  logic [PTR_WD-1:0] r_rd_ptr;
  logic [CNT_WD-1:0] r_count;

  logic              w_first_vld;
  logic              w_second_vld;
  trace_t            w_first;
  logic [1:0]        w_npush;
  logic              w_pop;
  logic [PTR_WD-1:0] w_wr_ptr1;

  // A lone younger push still lands in the first free slot.
  assign w_first_vld  = i_push0 | i_push1;
  assign w_second_vld = i_push0 & i_push1;
  assign w_first      = i_push0 ? i_data0 : i_data1;
  assign w_npush      = {1'b0, i_push0} + {1'b0, i_push1};
  assign w_pop        = (r_count != CNT_WD'(0));
  assign w_wr_ptr1    = r_wr_ptr + PTR_WD'(1);

  assign o_rd_valid = w_pop;
  assign o_rd_data  = r_mem[r_rd_ptr];
  assign o_count    = r_count;
  assign o_full     = (r_count >= CNT_WD'(TRACE_DEPTH - 1));

  // Entry storage, written in program order.
  always_ff @(posedge clk) begin
    if (w_first_vld) begin
      r_mem[r_wr_ptr] <= w_first;
    end
    if (w_second_vld) begin
      r_mem[w_wr_ptr1] <= i_data1;
    end
  end

  // Pointer and occupancy bookkeeping; reset discards any queued entries.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= PTR_WD'(0);
      r_rd_ptr <= PTR_WD'(0);
      r_count  <= CNT_WD'(0);
    end else begin
      r_wr_ptr <= r_wr_ptr + PTR_WD'(w_npush);
      r_rd_ptr <= r_rd_ptr + PTR_WD'(w_pop);
      r_count  <= r_count + CNT_WD'(w_npush) - CNT_WD'(w_pop);
    end
  end

endmodule

// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage
// Write-back stage of the dual-issue pipeline.
//   clk, rst           : clock, asynchronous active-low reset
//   stall, flush       : stall vector (bit 5 belongs to this stage), flush
//   mem_to_wb_bus      : two slots from the memory stage, lower slot older
//   wb_to_rf_bus       : two register-file write ports plus merged HI/LO write
//   stallreq_wb        : trace FIFO cannot take another dual retirement
//   debug_wb_*         : single-port retirement trace, one entry per cycle
// -----------------------------------------------------------------------------
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int TRACE_DEPTH = 4,
  parameter int SLOT_WD     = MEM_TO_WB_WD
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [STALLBUS_WD-1:0] stall,
  input  logic                   flush,
  input  logic [2*SLOT_WD-1:0]   mem_to_wb_bus,
  output logic [WB_TO_RF_WD-1:0] wb_to_rf_bus,
  output logic                   stallreq_wb,
  output logic [31:0]            debug_wb_pc,
  output logic [3:0]             debug_wb_rf_wen,
  output logic [4:0]             debug_wb_rf_wnum,
  output logic [31:0]            debug_wb_rf_wdata
);

  localparam int TRACE_WD = $bits(trace_t);

  logic [2*SLOT_WD-1:0]         r_bus;
  logic [31:0]                  r_dbg_pc;
  logic                         r_dbg_we;
  logic [4:0]                   r_dbg_wnum;
  logic [31:0]                  r_dbg_wdata;

  logic                         w_accept;
  slot_t                        w_old;
  slot_t                        w_yng;
  rf_bus_t                      w_rf;
  trace_t                       w_in_trace0;
  trace_t                       w_in_trace1;
  logic                         w_push0;
  logic                         w_push1;
  logic                         w_rd_valid;
  trace_t                       w_rd_data;
  logic [$clog2(TRACE_DEPTH):0] w_trace_count;
  logic                         w_unused_bits;

  assign w_accept = ~flush & (stall[WB_STALL_BIT] == NoStop);

  // Pipeline register: flush beats load, a stall holds the current bundle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bus <= {(2*SLOT_WD){1'b0}};
    end else if (flush) begin
      r_bus <= {(2*SLOT_WD){1'b0}};
    end else if (w_accept) begin
      r_bus <= mem_to_wb_bus;
    end else begin
      r_bus <= r_bus;
    end
  end

  assign w_old = slot_t'(r_bus[SLOT_WD-1:0]);
  assign w_yng = slot_t'(r_bus[2*SLOT_WD-1:SLOT_WD]);

  // Register-file ports and HI/LO merge; the younger slot wins every overlap.
  always_comb begin
    w_rf.wdata0 = w_old.wdata;
    w_rf.waddr0 = w_old.waddr;
    w_rf.wdata1 = w_yng.wdata;
    w_rf.waddr1 = w_yng.waddr;
    w_rf.we1    = w_yng.we;
    if (same_dest_conflict(w_old.we, w_old.waddr, w_yng.we, w_yng.waddr)) begin
      w_rf.we0 = 1'b0;
    end else begin
      w_rf.we0 = w_old.we;
    end
    w_rf.hilo.hi_we = w_old.hilo.hi_we | w_yng.hilo.hi_we;
    w_rf.hilo.lo_we = w_old.hilo.lo_we | w_yng.hilo.lo_we;
    if (w_yng.hilo.hi_we) begin
      w_rf.hilo.hi = w_yng.hilo.hi;
    end else begin
      w_rf.hilo.hi = w_old.hilo.hi;
    end
    if (w_yng.hilo.lo_we) begin
      w_rf.hilo.lo = w_yng.hilo.lo;
    end else begin
      w_rf.hilo.lo = w_old.hilo.lo;
    end
  end

  assign wb_to_rf_bus = w_rf;

  // Trace entries are taken straight from the incoming bus on the accepting edge.
  assign w_in_trace0 = trace_t'(mem_to_wb_bus[TRACE_WD-1:0]);
  assign w_in_trace1 = trace_t'(mem_to_wb_bus[SLOT_WD +: TRACE_WD]);
  assign w_push0     = w_accept & (w_in_trace0.pc != 32'd0);
  assign w_push1     = w_accept & (w_in_trace1.pc != 32'd0);

  wb_stage_trace_fifo #(
    .TRACE_DEPTH (TRACE_DEPTH)
  ) u_trace_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push0    (w_push0),
    .i_data0    (w_in_trace0),
    .i_push1    (w_push1),
    .i_data1    (w_in_trace1),
    .o_rd_valid (w_rd_valid),
    .o_rd_data  (w_rd_data),
    .o_count    (w_trace_count),
    .o_full     (stallreq_wb)
  );

  // Debug trace registers: show the popped entry, or an idle (all-zero) beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dbg_pc    <= 32'd0;
      r_dbg_we    <= 1'b0;
      r_dbg_wnum  <= 5'd0;
      r_dbg_wdata <= 32'd0;
    end else if (w_rd_valid) begin
      r_dbg_pc    <= w_rd_data.pc;
      r_dbg_we    <= w_rd_data.we;
      r_dbg_wnum  <= w_rd_data.waddr;
      r_dbg_wdata <= w_rd_data.wdata;
    end else begin
      r_dbg_pc    <= 32'd0;
      r_dbg_we    <= 1'b0;
      r_dbg_wnum  <= 5'd0;
      r_dbg_wdata <= 32'd0;
    end
  end

  assign debug_wb_pc       = r_dbg_pc;
  assign debug_wb_rf_wen   = {4{r_dbg_we}};
  assign debug_wb_rf_wnum  = r_dbg_wnum;
  assign debug_wb_rf_wdata = r_dbg_wdata;

  // Fields this stage deliberately ignores.
  assign w_unused_bits = ^{stall[STALLBUS_WD-2:0], w_old.pc, w_yng.pc, w_trace_count};

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [5:0]   stall;
  logic         flush;
  logic [271:0] bus;
  logic [141:0] rf;
  logic         sreq;
  logic [31:0]  dpc;
  logic [3:0]   dwen;
  logic [4:0]   dwnum;
  logic [31:0]  dwdata;

  wb_stage #(.TRACE_DEPTH(DEPTH)) dut (
    .clk               (clk),
    .rst               (rst),
    .stall             (stall),
    .flush             (flush),
    .mem_to_wb_bus     (bus),
    .wb_to_rf_bus      (rf),
    .stallreq_wb       (sreq),
    .debug_wb_pc       (dpc),
    .debug_wb_rf_wen   (dwen),
    .debug_wb_rf_wnum  (dwnum),
    .debug_wb_rf_wdata (dwdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } tent_t;

  // Behavioural model: retirement queue, captured bundle, current debug beat.
  tent_t        q[$];
  logic [271:0] m_reg;
  tent_t        m_dbg;
  logic [31:0]  last_pc;
  logic [31:0]  pc_ctr;
  int           tests = 0;
  int           fails = 0;

  task automatic chk(input string name, input logic [141:0] act, input logic [141:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [135:0] mk_slot(input logic [31:0] pc, input logic we,
                                           input logic [4:0] wa, input logic [31:0] wd,
                                           input logic hwe, input logic lwe,
                                           input logic [31:0] hi, input logic [31:0] lo);
    return {hwe, lwe, hi, lo, pc, we, wa, wd};
  endfunction

  // Expected wb_to_rf_bus from the captured bundle, written from the rules.
  function automatic logic [141:0] exp_rf();
    logic [135:0] o, y;
    logic         we0, hwe, lwe;
    logic [31:0]  hi, lo;
    o   = m_reg[135:0];
    y   = m_reg[271:136];
    we0 = o[37];
    if (o[37] && y[37] && (o[36:32] == y[36:32])) we0 = 1'b0;
    hwe = o[135] | y[135];
    lwe = o[134] | y[134];
    hi  = y[135] ? y[133:102] : o[133:102];
    lo  = y[134] ? y[101:70]  : o[101:70];
    return {hwe, lwe, hi, lo, y[37], y[36:32], y[31:0], we0, o[36:32], o[31:0]};
  endfunction

  task automatic model_reset();
    q.delete();
    m_reg   = '0;
    m_dbg   = '{32'd0, 1'b0, 5'd0, 32'd0};
    last_pc = 32'd0;
  endtask

  // What one rising edge does: pop one retired entry, then accept the bundle.
  task automatic model_edge();
    logic [135:0] sl;
    tent_t        e;
    if (!rst) begin
      model_reset();
    end else begin
      if (q.size() > 0) m_dbg = q.pop_front();
      else              m_dbg = '{32'd0, 1'b0, 5'd0, 32'd0};
      if (flush) begin
        m_reg = '0;
      end else if (stall[5] == 1'b0) begin
        m_reg = bus;
        for (int s = 0; s < 2; s++) begin
          sl = bus[s*136 +: 136];
          if (sl[69:38] != 32'd0) begin
            e.pc = sl[69:38]; e.we = sl[37]; e.waddr = sl[36:32]; e.wdata = sl[31:0];
            q.push_back(e);
          end
        end
      end
    end
  endtask

  task automatic compare();
    chk("rf_bus",    rf, exp_rf());
    chk("stallreq",  142'(sreq),   142'(q.size() >= DEPTH - 1));
    chk("dbg_pc",    142'(dpc),    142'(m_dbg.pc));
    chk("dbg_wen",   142'(dwen),   142'({4{m_dbg.we}}));
    chk("dbg_wnum",  142'(dwnum),  142'(m_dbg.waddr));
    chk("dbg_wdata", 142'(dwdata), 142'(m_dbg.wdata));
    if (dpc != 32'd0) begin
      tests++;
      if (!(dpc > last_pc)) begin
        fails++;
        $display("FAIL pc_order: got %0h after %0h, required ascending", dpc, last_pc);
      end
      last_pc = dpc;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic drive(input logic [271:0] b, input logic st, input logic fl);
    bus   = b;
    stall = {st, 5'($urandom)};
    flush = fl;
  endtask

  task automatic gen_slot(output logic [135:0] s);
    if ($urandom_range(0, 4) == 0) begin
      s = '0;
    end else begin
      s = mk_slot(pc_ctr, 1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                  1'($urandom), 1'($urandom), $urandom, $urandom);
      pc_ctr = pc_ctr + 32'd4;
    end
  endtask

  function automatic logic [271:0] dual(input logic [31:0] pc);
    return {mk_slot(pc + 32'd4, 1'b1, 5'd2, pc + 32'd4, 1'b0, 1'b0, 32'd0, 32'd0),
            mk_slot(pc,         1'b1, 5'd1, pc,         1'b0, 1'b0, 32'd0, 32'd0)};
  endfunction

  // Mid-cycle asynchronous reset, checked before any clock edge arrives.
  task automatic do_reset();
    #2 rst = 1'b0;
    #1;
    chk("rst_async_pc",   142'(dpc),  142'd0);
    chk("rst_async_wen",  142'(dwen), 142'd0);
    chk("rst_async_rf",   rf,         142'd0);
    chk("rst_async_sreq", 142'(sreq), 142'd0);
    model_reset();
    for (int i = 0; i < 2; i++) begin
      drive({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
             $urandom, 16'($urandom)}, 1'($urandom), 1'($urandom));
      step();
    end
    rst = 1'b1;
    drive('0, 1'b0, 1'b0);
    pc_ctr = 32'hBFC00000;
  endtask

  initial begin
    logic [135:0] s0, s1;
    logic [31:0]  pc;
    rst = 1'b0;
    model_reset();
    pc_ctr = 32'hBFC00000;
    drive({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
           $urandom, 16'($urandom)}, 1'b0, 1'b0);
    step();
    step();
    chk("reset_rf",   rf,         142'd0);
    chk("reset_pc",   142'(dpc),  142'd0);
    chk("reset_wen",  142'(dwen), 142'd0);
    chk("reset_sreq", 142'(sreq), 142'd0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive({8{$urandom}} | 272'd1, 1'b1, 1'b0);
      step();
    end
    chk("idle_wen", 142'(dwen), 142'd0);

    // Dual retirement: both writes at once, trace one per cycle.
    do_reset();
    drive({mk_slot(32'hBFC00004, 1'b1, 5'd4, 32'h22, 1'b0, 1'b0, 32'd0, 32'd0),
           mk_slot(32'hBFC00000, 1'b1, 5'd3, 32'h11, 1'b0, 1'b0, 32'd0, 32'd0)}, 1'b0, 1'b0);
    step();
    chk("dual_rf", 142'(rf[75:0]), 142'({1'b1, 5'd4, 32'h22, 1'b1, 5'd3, 32'h11}));
    chk("dual_dbg_n", 142'(dwen), 142'd0);
    drive('0, 1'b0, 1'b0);
    step();
    chk("dual_dbg_n1", 142'({dpc, dwen, dwnum, dwdata}), 142'({32'hBFC00000, 4'hF, 5'd3, 32'h11}));
    step();
    chk("dual_dbg_n2", 142'({dpc, dwen, dwnum, dwdata}), 142'({32'hBFC00004, 4'hF, 5'd4, 32'h22}));
    step();
    chk("dual_dbg_n3", 142'(dwen), 142'd0);

    // Same destination plus HI/LO merge.
    do_reset();
    drive({mk_slot(32'hBFC00004, 1'b1, 5'd5, 32'hBB, 1'b0, 1'b1, 32'd0, 32'd9),
           mk_slot(32'hBFC00000, 1'b1, 5'd5, 32'hAA, 1'b1, 1'b1, 32'd1, 32'd2)}, 1'b0, 1'b0);
    step();
    chk("conf_we0",   142'(rf[37]),     142'd0);
    chk("conf_port1", 142'(rf[75:38]),  142'({1'b1, 5'd5, 32'hBB}));
    chk("hilo_merge", 142'(rf[141:76]), 142'({1'b1, 1'b1, 32'd1, 32'd9}));
    drive('0, 1'b0, 1'b0);
    step();
    chk("conf_trace0", 142'({dpc, dwdata}), 142'({32'hBFC00000, 32'hAA}));
    step();
    chk("conf_trace1", 142'({dpc, dwdata}), 142'({32'hBFC00004, 32'hBB}));

    // Backpressure threshold and drain.
    do_reset();
    drive(dual(32'hBFC00000), 1'b0, 1'b0); step();
    chk("bp_sreq_cnt2", 142'(sreq), 142'd0);
    drive(dual(32'hBFC00008), 1'b0, 1'b0); step();
    chk("bp_sreq_cnt3", 142'(sreq), 142'd1);
    drive(dual(32'hBFC00010), 1'b1, 1'b0); step();
    chk("bp_sreq_fall", 142'(sreq), 142'd0);
    for (int i = 0; i < 3; i++) step();
    chk("bp_drained", 142'(dwen), 142'd0);
    pc = 32'hBFC00100;
    for (int i = 0; i < 20; i++) begin
      if (q.size() >= DEPTH - 1) begin
        drive(dual(pc), 1'b1, 1'b0);
      end else begin
        drive(dual(pc), 1'b0, 1'b0);
        pc = pc + 32'd8;
      end
      step();
    end

    // Flush with three entries queued: they still drain.
    do_reset();
    drive(dual(32'hBFC00000), 1'b0, 1'b0); step();
    drive(dual(32'hBFC00008), 1'b0, 1'b0); step();
    chk("flush_pre_sreq", 142'(sreq), 142'd1);
    drive(dual(32'hBFC00010), 1'b0, 1'b1); step();
    chk("flush_rf", rf, 142'd0);
    chk("flush_tr0", 142'(dpc), 142'(32'hBFC00004));
    drive('0, 1'b1, 1'b0); step();
    chk("flush_tr1", 142'(dpc), 142'(32'hBFC00008));
    step();
    chk("flush_tr2", 142'(dpc), 142'(32'hBFC0000C));
    step();
    chk("flush_tr3", 142'(dwen), 142'd0);

    // Reset in the middle of a drain discards the queue.
    drive(dual(32'hBFC00020), 1'b0, 1'b0); step();
    drive(dual(32'hBFC00028), 1'b0, 1'b0); step();
    do_reset();
    drive('0, 1'b1, 1'b0); step();
    chk("post_rst_wen",  142'(dwen), 142'd0);
    chk("post_rst_sreq", 142'(sreq), 142'd0);

    // Randomised traffic honouring the stall request.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      gen_slot(s0);
      gen_slot(s1);
      drive({s1, s0},
            (q.size() >= DEPTH - 1) ? 1'b1 : ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 19) == 0));
      step();
    end
    drive('0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
Write-back stage of the dual-issue pipeline, directly downstream of the memory stage.
- Registers the two-slot mem_to_wb_bus and drives both register-file write ports plus a merged HI/LO write.
- Serialises the up-to-two retirements per cycle into the single-port debug trace interface through a small trace FIFO.
- Requests a pipeline stall when the FIFO cannot absorb another dual retirement.

Parameters:
TRACE_DEPTH, 4, trace FIFO entries; power of two, minimum 4.
SLOT_WD, 136, width of one slot of mem_to_wb_bus (equals MEM_TO_WB_WD).

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-low reset.
stall  in  StallBus  pipeline stall vector; this stage uses stall[5].
flush  in  1  exception flush.
mem_to_wb_bus  in  2*SLOT_WD  two slots, each {hilo[65:0], pc[31:0], we, waddr[4:0], wdata[31:0]}; lower slot is older in program order.
wb_to_rf_bus  out  142  {hilo_merged[65:0], we1, waddr1[4:0], wdata1[31:0], we0, waddr0[4:0], wdata0[31:0]}.
stallreq_wb  out  1  stall request to the control unit.
debug_wb_pc  out  32  retired PC.
debug_wb_rf_wen  out  4  byte write enable; the slot's we replicated to 4 bits.
debug_wb_rf_wnum  out  5  destination register.
debug_wb_rf_wdata  out  32  written value.

Behaviour:
- Reset (rst=0, asynchronous):
  - pipeline register, FIFO pointers, count and all debug outputs go to 0.
  - wb_to_rf_bus=0 and stallreq_wb=0 as a consequence.
- Pipeline register priority on each edge:
  - flush → load 0.
  - else stall[5]==NoStop → load mem_to_wb_bus.
  - else hold.
- Slot validity: a slot is valid when its pc != 0; an all-zero slot is a bubble.
- Register-file outputs are combinational from the pipeline register (0-cycle latency after capture).
  - Port 0 is the older slot, port 1 the younger.
- Same-destination rule: if both slots have we=1 and equal waddr, port 0's we is forced to 0 (younger wins).
- Writes are held asserted while the register holds during a stall; repeated writes are idempotent.
- HI/LO merge: hilo = {hi_we, lo_we, hi[31:0], lo[31:0]}. For each of HI and LO independently, the younger slot's field is used if its *_we is set, else the older slot's. Each merged *_we is the OR of the two slots' *_we.
- Trace FIFO push:
  - occurs on the same edge as a pipeline-register load (stall[5]==NoStop and no flush);
  - pushes the valid incoming slots, 0, 1 or 2 per edge, older first;
  - each entry is {pc, we, waddr, wdata}.
- Trace FIFO pop:
  - one entry per edge when count != 0; the popped entry is loaded into the debug output registers;
  - when count == 0, the debug registers load 0 (wen=0, pc=0).
- Latency: a slot accepted at edge N appears on the debug port at edge N+1 at the earliest. The second slot of a pair appears at N+2.
- Push and pop on the same edge are allowed; count_next = count + pushes − pop.
- Pointers are log2(TRACE_DEPTH) bits and wrap modulo TRACE_DEPTH. count is log2(TRACE_DEPTH)+1 bits.
- stallreq_wb = (count >= TRACE_DEPTH−1), combinational from the registered count.
- No-overflow invariant: while stallreq_wb=0 and an accept occurs, count_next <= TRACE_DEPTH−1. Overflow is unreachable by design and is a verification assertion. There is no RTL recovery path.
- flush clears only the pipeline register. FIFO contents are already-retired instructions and must drain.
- Reset mid-drain discards all FIFO contents immediately.

Decomposition:
- Shared defines header: SLOT_WD/MEM_TO_WB_WD, HILO_WD=66, WB_TO_RF_WD=142, StallBus, Stop/NoStop, and slot field offsets.
- Sub-module trace_fifo (parameter TRACE_DEPTH):
  - two write ports with ordered push, one read port;
  - count and full-threshold output.
- wb_stage holds the pipeline register, the write-conflict/HI-LO merge logic and the debug registers.

Test Plan:
- Reset: hold rst=0 with random inputs → all outputs 0; release → debug_wb_rf_wen=0 until first accept.
- Dual retire: slot0 {pc=0xBFC00000, we=1, waddr=3, wdata=0x11}, slot1 {pc=0xBFC00004, we=1, waddr=4, wdata=0x22} accepted at edge N → wb_to_rf_bus ports carry both writes in cycle N. Debug shows pc 0xBFC00000/r3/0x11 after N+1, then 0xBFC00004/r4/0x22 after N+2, then wen=0.
- Write conflict: both slots write r5 (0xAA older, 0xBB younger) → we0=0, we1=1, wdata1=0xBB. The trace still emits both entries in order.
- HI/LO merge: older {hi_we=1, lo_we=1, hi=1, lo=2}, younger {hi_we=0, lo_we=1, lo=9} → merged {1,1,hi=1,lo=9}.
- Backpressure (TRACE_DEPTH=4): accept dual bundles every cycle → stallreq_wb rises when count reaches 3. With stall[5]=Stop, no pushes occur, the FIFO drains one entry per cycle, and stallreq falls at count 2. No entry is lost or duplicated; the PC sequence is strictly ascending.
- Flush/reset mid-operation: flush with 3 entries queued → register cleared, the 3 entries still trace over the next 3 cycles. Assert rst=0 mid-drain → debug outputs 0 immediately (asynchronous), count=0.
